core_div: RTL

CORE_DIV -- requirements
Module: core_div

---
 rtl/core_div.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/core_div.sv
// rtl/core_div.sv - 32-step restoring divider with register-file write-back
// Signed ops run on magnitudes; sign fix-up is applied on the final step.
module core_div (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_in,
   input  logic [1:0]  op_in,
   input  logic [31:0] dividend_in,
   input  logic [31:0] divisor_in,
   input  logic [4:0]  write_addr_in,
   input  logic        cancel_in,
   output logic        busy_out,
   output logic        we_out,
   output logic [4:0]  write_addr_out,
   output logic [31:0] write_data_out
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t      state_q, state_d;
   logic [4:0]  count_q, count_d;
   logic        op_rem_q, op_rem_d;
   logic [4:0]  addr_q, addr_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] quo_q, quo_d;
   logic [31:0] div_q, div_d;
   logic        quo_neg_q, quo_neg_d;
   logic        rem_neg_q, rem_neg_d;
   logic        busy_q, busy_d;
   logic        we_q, we_d;
   logic [4:0]  waddr_q, waddr_d;
   logic [31:0] wdata_q, wdata_d;

   logic        in_signed, a_neg, b_neg;
   logic [31:0] a_mag, b_mag;
   logic [32:0] shifted;
   logic        borrow;
   logic [31:0] step_rem, step_quo;
   logic [31:0] q_res, r_res, result;

   assign in_signed = ~op_in[0];
   assign a_neg     = in_signed & dividend_in[31];
   assign b_neg     = in_signed & divisor_in[31];
   assign a_mag     = a_neg ? (~dividend_in + 32'd1) : dividend_in;
   assign b_mag     = b_neg ? (~divisor_in + 32'd1) : divisor_in;

   // Partial remainder stays below the divisor, so the difference always fits 32 bits.
   assign shifted   = {rem_q, quo_q[31]};
   assign borrow    = shifted < {1'b0, div_q};
   assign step_rem  = borrow ? shifted[31:0] : (shifted[31:0] - div_q);
   assign step_quo  = {quo_q[30:0], ~borrow};

   assign q_res     = quo_neg_q ? (~step_quo + 32'd1) : step_quo;
   assign r_res     = rem_neg_q ? (~step_rem + 32'd1) : step_rem;
   assign result    = op_rem_q ? r_res : q_res;

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      op_rem_d  = op_rem_q;
      addr_d    = addr_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      div_d     = div_q;
      quo_neg_d = quo_neg_q;
      rem_neg_d = rem_neg_q;
      we_d      = 1'b0;
      waddr_d   = 5'd0;
      wdata_d   = 32'd0;
      case (state_q)
         IDLE: begin
            if (start_in && !cancel_in) begin
               op_rem_d  = op_in[1];
               addr_d    = write_addr_in;
               rem_d     = 32'd0;
               quo_d     = a_mag;
               div_d     = b_mag;
               quo_neg_d = a_neg ^ b_neg;
               rem_neg_d = a_neg;
               count_d   = 5'd0;
               if (divisor_in == 32'd0) begin
                  state_d = DONE;
                  we_d    = (write_addr_in != 5'd0);
                  if (we_d) begin
                     waddr_d = write_addr_in;
                     wdata_d = op_in[1] ? dividend_in : 32'hFFFF_FFFF;
                  end
               end else begin
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            if (cancel_in) begin
               state_d = IDLE;
            end else begin
               rem_d   = step_rem;
               quo_d   = step_quo;
               count_d = count_q + 5'd1;
               if (count_q == 5'd31) begin
                  state_d = DONE;
                  we_d    = (addr_q != 5'd0);
                  if (we_d) begin
                     waddr_d = addr_q;
                     wdata_d = result;
                  end
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         count_q   <= 5'd0;
         op_rem_q  <= 1'b0;
         addr_q    <= 5'd0;
         rem_q     <= 32'd0;
         quo_q     <= 32'd0;
         div_q     <= 32'd0;
         quo_neg_q <= 1'b0;
         rem_neg_q <= 1'b0;
         busy_q    <= 1'b0;
         we_q      <= 1'b0;
         waddr_q   <= 5'd0;
         wdata_q   <= 32'd0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         op_rem_q  <= op_rem_d;
         addr_q    <= addr_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         div_q     <= div_d;
         quo_neg_q <= quo_neg_d;
         rem_neg_q <= rem_neg_d;
         busy_q    <= busy_d;
         we_q      <= we_d;
         waddr_q   <= waddr_d;
         wdata_q   <= wdata_d;
      end
   end

   assign busy_out       = busy_q;
   assign we_out         = we_q;
   assign write_addr_out = waddr_q;
   assign write_data_out = wdata_q;

endmodule
